// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller:
// default operand width and the controller state encoding.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder used as the one-bit step of the serial datapath.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: captures two WIDTH-bit operands on Start,
// adds them LSB-first one bit per clock through a single full_adder and
// commits Sum/Cout/Overflow together with a one-cycle Done pulse.
// Optional subtraction (A-B) is enabled by defining SERIAL_ADD_SUB_EN;
// without it the Sub port is accepted but ignored.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow,
    output logic             Busy,
    output logic             Done
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t            r_state;
    state_t            w_next_state;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_res;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_carry;
    logic              r_sub;

    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;

    logic              w_sub_in;
    logic              w_b_bit;
    logic              w_fa_sum;
    logic              w_fa_cout;
    logic              w_last;
    logic              w_busy;
    logic              w_done;

`ifdef SERIAL_ADD_SUB_EN
    assign w_sub_in = Sub;
`else
    // Sub is kept on the interface but has no effect in the add-only build.
    logic w_unused_sub;
    assign w_unused_sub = Sub;
    assign w_sub_in     = 1'b0;
`endif

    // B is inverted for subtraction; the +1 comes from the preset carry.
    assign w_b_bit = r_b[0] ^ r_sub;
    assign w_last  = (r_cnt == LAST_CNT);

    full_adder u_bit_step (
        .i_a    (r_a[0]),
        .i_b    (w_b_bit),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: Start is only honoured in IDLE.
    // NOTE: the default assignment at the top keeps this combinational
    // block from inferring a latch on any unlisted path.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:  if (Start) w_next_state = ST_LOAD;
            ST_LOAD:  w_next_state = ST_SHIFT;
            ST_SHIFT: if (w_last) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            ST_LOAD, ST_SHIFT: w_busy = 1'b1;
            ST_DONE:           w_done = 1'b1;
            default:           ;
        endcase
    end

    // Serial datapath: operand capture, carry preset, one bit per SHIFT cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_a   <= A;
                        r_b   <= B;
                        r_sub <= w_sub_in;
                    end
                end
                ST_LOAD: begin
                    r_cnt   <= '0;
                    r_carry <= r_sub;
                    r_res   <= '0;
                end
                ST_SHIFT: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= {w_fa_sum, r_res[WIDTH-1:1]};
                    r_carry <= w_fa_cout;
                    r_cnt   <= r_cnt + CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    // Result registers: updated together only on the final bit-step, so
    // partial sums never reach the outputs. r_carry there is the carry
    // into the MSB, which gives the signed overflow flag.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (r_state == ST_SHIFT && w_last) begin
            r_sum  <= {w_fa_sum, r_res[WIDTH-1:1]};
            r_cout <= w_fa_cout;
            r_ovf  <= r_carry ^ w_fa_cout;
        end
    end

    assign Sum      = r_sum;
    assign Cout     = r_cout;
    assign Overflow = r_ovf;
    assign Busy     = w_busy;
    assign Done     = w_done;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8). Expected results come
// from an integer-arithmetic model; honours SERIAL_ADD_SUB_EN if defined.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             Clk;
    logic             Reset_n;
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Sub;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Overflow;
    logic             Busy;
    logic             Done;

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Start    (Start),
        .A        (A),
        .B        (B),
        .Sub      (Sub),
        .Sum      (Sum),
        .Cout     (Cout),
        .Overflow (Overflow),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer add/subtract, carry = no unsigned wrap
    // (or no borrow), overflow = signed result outside [-128, 127].
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic sub,
                                  output logic [7:0] s, output logic c, output logic v);
        int   ua = int'(a);
        int   ub = int'(b);
        int   sa = int'($signed(a));
        int   sb = int'($signed(b));
        int   r;
        int   sr;
        logic eff;
`ifdef SERIAL_ADD_SUB_EN
        eff = sub;
`else
        eff = sub & 1'b0;
`endif
        if (eff) begin
            r  = ua - ub;
            sr = sa - sb;
            c  = (ua >= ub);
        end else begin
            r  = ua + ub;
            sr = sa + sb;
            c  = (r > 255);
        end
        s = r[7:0];
        v = (sr > 127) || (sr < -128);
    endfunction

    // One operation from IDLE. Called at #1 after a rising edge. Done must be
    // seen WIDTH+1 edges after the Start edge (the WIDTH+2-th edge counting
    // the Start edge itself), with Busy high for WIDTH+1 cycles before it.
    // With inject set, Start is pulsed with other operands mid-SHIFT.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic sub, input logic [7:0] es, input logic ec,
                          input logic ev, input bit inject);
        logic [7:0] prev_sum;
        int         n;
        int         busy_cnt;
        int         extra_done;
        bit         leaked;
        prev_sum = Sum;
        A        = a;
        B        = b;
        Sub      = sub;
        Start    = 1'b1;
        @(posedge Clk); #1;
        Start    = 1'b0;
        n        = 0;
        busy_cnt = 0;
        leaked   = 1'b0;
        while (!Done && n < 40) begin
            if (Busy) busy_cnt++;
            if (Sum !== prev_sum) leaked = 1'b1;
            if (inject && n == 4) begin
                Start = 1'b1;
                A     = ~a;
                B     = a;
                Sub   = ~sub;
            end else if (inject && n == 5) begin
                Start = 1'b0;
            end
            @(posedge Clk); #1;
            n++;
        end
        Start = 1'b0;
        check({tag, "_latency"}, n, WIDTH + 1);
        check({tag, "_busy_cycles"}, busy_cnt, WIDTH + 1);
        check({tag, "_no_partial"}, {31'd0, leaked}, 32'd0);
        check({tag, "_busy_at_done"}, {31'd0, Busy}, 32'd0);
        check({tag, "_sum"}, {24'd0, Sum}, {24'd0, es});
        check({tag, "_cout"}, {31'd0, Cout}, {31'd0, ec});
        check({tag, "_ovf"}, {31'd0, Overflow}, {31'd0, ev});
        @(posedge Clk); #1;
        check({tag, "_done_pulse"}, {31'd0, Done}, 32'd0);
        check({tag, "_sum_hold"}, {24'd0, Sum}, {24'd0, es});
        if (inject) begin
            extra_done = 0;
            for (int i = 0; i < WIDTH + 4; i++) begin
                if (Done) extra_done++;
                @(posedge Clk); #1;
            end
            check({tag, "_single_done"}, extra_done, 0);
            check({tag, "_sum_kept"}, {24'd0, Sum}, {24'd0, es});
        end
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;
        logic [7:0] ms;
        logic       mc;
        logic       mv;
        int         rst_done;

        Reset_n = 1'b0;
        Start   = 1'b0;
        A       = '0;
        B       = '0;
        Sub     = 1'b0;
        #12;
        check("rst_sum",  {24'd0, Sum},      32'd0);
        check("rst_cout", {31'd0, Cout},     32'd0);
        check("rst_ovf",  {31'd0, Overflow}, 32'd0);
        check("rst_busy", {31'd0, Busy},     32'd0);
        check("rst_done", {31'd0, Done},     32'd0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        // Carry out of the MSB, result wraps to zero.
        run_op("ff_plus_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        // Signed overflow without carry.
        run_op("5a_plus_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
        // New Start during SHIFT must be dropped.
        run_op("ignore_start", 8'h21, 8'h42, 1'b0, 8'h63, 1'b0, 1'b0, 1'b1);

        // Reset three bit-steps into SHIFT aborts the operation.
        A     = 8'hC3;
        B     = 8'h11;
        Sub   = 1'b0;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (4) begin
            @(posedge Clk); #1;
        end
        Reset_n = 1'b0;
        #1;
        check("abort_sum",  {24'd0, Sum},      32'd0);
        check("abort_busy", {31'd0, Busy},     32'd0);
        check("abort_done", {31'd0, Done},     32'd0);
        rst_done = 0;
        repeat (3) begin
            @(posedge Clk); #1;
            if (Done) rst_done++;
        end
        Reset_n = 1'b1;
        repeat (WIDTH + 3) begin
            @(posedge Clk); #1;
            if (Done || Busy) rst_done++;
        end
        check("abort_no_done", rst_done, 0);
        check("abort_cout", {31'd0, Cout},     32'd0);
        check("abort_ovf",  {31'd0, Overflow}, 32'd0);
        run_op("after_abort", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        run_op("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
`else
        run_op("sub_ignored", 8'h10, 8'h20, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
`endif

        // Randomized operands against the reference model.
        for (int k = 0; k < 24; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, ms, mc, mv);
            run_op($sformatf("rand%0d", k), ra, rb, rs, ms, mc, mv, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
